envelope_bank: RTL

//  NUM_CH independent AY/YM-style envelope generators in one block, one per PSG voice.

---
 rtl/envelope_bank_if.sv | 24 ++
 rtl/envelope_bank.sv | 103 ++++++++++
 2 files changed

// File: rtl/envelope_bank_if.sv
// Register-file side bundle for envelope_bank: shape/period controls in, levels and status out.
interface envelope_bank_if #(
  parameter int NUM_CH        = 3,
  parameter int PERIOD_BITS   = 16,
  parameter int ENVELOPE_BITS = 4
) ();
  logic                            enable;
  logic [NUM_CH-1:0]               shape_wr;
  logic [4*NUM_CH-1:0]             shape_in;
  logic [PERIOD_BITS*NUM_CH-1:0]   period;
  logic [ENVELOPE_BITS*NUM_CH-1:0] out;
  logic [NUM_CH-1:0]               holding;
  logic [NUM_CH-1:0]               cycle_done;

  modport master (
    output enable, shape_wr, shape_in, period,
    input  out, holding, cycle_done
  );

  modport slave (
    input  enable, shape_wr, shape_in, period,
    output out, holding, cycle_done
  );
endinterface

// File: rtl/envelope_bank.sv
// NUM_CH independent AY/YM envelope generators; each channel restarts on its own shape write
// and either cycles ramps forever or freezes at a held level.
module envelope_bank #(
  parameter int NUM_CH        = 3,
  parameter int PERIOD_BITS   = 16,
  parameter int ENVELOPE_BITS = 4
) (
  input  logic           clk,
  input  logic           reset,
  envelope_bank_if.slave bus
);

  localparam logic [ENVELOPE_BITS-1:0] MAX   = '1;
  localparam logic [ENVELOPE_BITS-1:0] S_ONE = ENVELOPE_BITS'(1);
  localparam logic [PERIOD_BITS-1:0]   P_ONE = PERIOD_BITS'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [PERIOD_BITS-1:0]   pcnt_q, pcnt_d;
      logic [ENVELOPE_BITS-1:0] step_q, step_d;
      logic                     inv_q, inv_d;
      logic                     hold_q, hold_d;
      logic [3:0]               shape_q, shape_d;
      logic                     done_q, done_d;

      logic [3:0]             shape_slice;
      logic [PERIOD_BITS-1:0] period_ch;
      logic [PERIOD_BITS-1:0] limit;
      logic                   hold_eff;
      logic                   alt_eff;
      logic                   held_max;

      assign shape_slice = bus.shape_in[4*gi +: 4];
      assign period_ch   = bus.period[PERIOD_BITS*gi +: PERIOD_BITS];
      // A zero period behaves as one: tick on every enable.
      assign limit       = (period_ch == '0) ? '0 : period_ch - P_ONE;

      // shape bits: [3]=continue [2]=attack [1]=alternate [0]=hold
      assign hold_eff = shape_q[0] | ~shape_q[3];
      assign alt_eff  = shape_q[3] & shape_q[1];
      assign held_max = shape_q[3] & (shape_q[2] ^ shape_q[1]);

      always_comb begin
        pcnt_d  = pcnt_q;
        step_d  = step_q;
        inv_d   = inv_q;
        hold_d  = hold_q;
        shape_d = shape_q;
        done_d  = 1'b0;
        if (bus.shape_wr[gi]) begin
          shape_d = shape_slice;
          pcnt_d  = '0;
          step_d  = '0;
          inv_d   = ~shape_slice[2];
          hold_d  = 1'b0;
        end else if (bus.enable && !hold_q) begin
          if (pcnt_q >= limit) begin
            pcnt_d = '0;
            if (step_q != MAX) begin
              step_d = step_q + S_ONE;
            end else begin
              done_d = 1'b1;
              if (hold_eff) begin
                hold_d = 1'b1;
                step_d = MAX;
                inv_d  = ~held_max;
              end else begin
                step_d = '0;
                inv_d  = inv_q ^ alt_eff;
              end
            end
          end else begin
            pcnt_d = pcnt_q + P_ONE;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pcnt_q  <= '0;
          step_q  <= MAX;
          inv_q   <= 1'b1;
          hold_q  <= 1'b1;
          shape_q <= 4'b0000;
          done_q  <= 1'b0;
        end else begin
          pcnt_q  <= pcnt_d;
          step_q  <= step_d;
          inv_q   <= inv_d;
          hold_q  <= hold_d;
          shape_q <= shape_d;
          done_q  <= done_d;
        end
      end

      assign bus.out[ENVELOPE_BITS*gi +: ENVELOPE_BITS] = inv_q ? (MAX - step_q) : step_q;
      assign bus.holding[gi]    = hold_q;
      assign bus.cycle_done[gi] = done_q;
    end
  endgenerate

endmodule
